// File: rtl/cla_pkg.sv
`default_nettype none
// =============================================================================
// Module      : cla_pkg
// Description : Shared defaults and run-state encoding for the CLA adder,
//               its response checker and their benches.
// Revision    : 1.0 - initial release
// =============================================================================
package cla_pkg;

    localparam int c_WIDTH_DEFAULT       = 4;
    localparam int c_NUM_VECTORS_DEFAULT = 50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_response_checker_if.sv
`default_nettype none
// =============================================================================
// Module      : cla_response_checker_if
// Description : Valid/ready bundle carrying an adder operand vector together
//               with the adder's observed response.
// Revision    : 1.0 - initial release
// =============================================================================
interface cla_response_checker_if #(
    parameter int WIDTH = cla_pkg::c_WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, ci, sum, cout,
        input  in_ready
    );

    modport slave (
        input  in_valid, a, b, ci, sum, cout,
        output in_ready
    );
endinterface : cla_response_checker_if
`default_nettype wire

// File: rtl/cla_ref_model.sv
`default_nettype none
// =============================================================================
// Module      : cla_ref_model
// Description : Combinational expected-value generator {cout,sum} = a + b + ci.
// Revision    : 1.0 - initial release
// =============================================================================
module cla_ref_model #(
    parameter int WIDTH = cla_pkg::c_WIDTH_DEFAULT
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_ci,
    output logic      [WIDTH:0]   o_expected
);

    // Operands are widened first so the carry lands in the top bit.
    assign o_expected = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(i_ci);

endmodule : cla_ref_model
`default_nettype wire

// File: rtl/cla_response_checker.sv
`default_nettype none
// =============================================================================
// Module      : cla_response_checker
// Description : Checks adder responses against a reference sum, counts vectors
//               and mismatches, captures the first failure, reports pass/fail.
// Revision    : 1.0 - initial release
// =============================================================================
module cla_response_checker
    import cla_pkg::*;
#(
    parameter int WIDTH       = c_WIDTH_DEFAULT,
    parameter int NUM_VECTORS = c_NUM_VECTORS_DEFAULT,
    parameter int CNT_W       = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    cla_response_checker_if.slave   bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        vec_count,
    output logic [CNT_W-1:0]        err_count,
    output logic                    fail_valid,
    output logic [CNT_W-1:0]        fail_idx,
    output logic [WIDTH:0]          fail_obs
);

    // The acceptance counter must reach NUM_VECTORS even if the reported
    // counters are narrower, so it is sized for whichever is larger.
    localparam int c_NV_W  = $clog2(NUM_VECTORS + 1);
    localparam int c_ACC_W = (CNT_W > c_NV_W) ? CNT_W : c_NV_W;
    localparam logic [c_ACC_W-1:0] c_LAST = c_ACC_W'(NUM_VECTORS - 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [c_ACC_W-1:0] r_acc_cnt;

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic               r_s1_ci;
    logic [WIDTH:0]     r_s1_obs;

    logic [CNT_W-1:0]   r_vec_count;
    logic [CNT_W-1:0]   r_err_count;
    logic               r_fail_valid;
    logic [CNT_W-1:0]   r_fail_idx;
    logic [WIDTH:0]     r_fail_obs;

    logic               w_hs;
    logic [WIDTH:0]     w_expected;
    logic               w_mismatch;

    cla_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .i_ci       (r_s1_ci),
        .o_expected (w_expected)
    );

    assign w_hs       = bus.in_valid && r_in_ready;
    assign w_mismatch = (r_s1_obs != w_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_acc_cnt    <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_ci      <= 1'b0;
            r_s1_obs     <= '0;
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_obs   <= '0;
        end else begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_a   <= bus.a;
                r_s1_b   <= bus.b;
                r_s1_ci  <= bus.ci;
                r_s1_obs <= {bus.cout, bus.sum};
            end

            if (r_s1_valid) begin
                r_vec_count <= r_vec_count + CNT_W'(1);
                if (w_mismatch) begin
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + CNT_W'(1);
                    end
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_idx   <= r_vec_count;
                        r_fail_obs   <= r_s1_obs;
                    end
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_acc_cnt    <= '0;
                        r_vec_count  <= '0;
                        r_err_count  <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_idx   <= '0;
                        r_fail_obs   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_acc_cnt <= r_acc_cnt + c_ACC_W'(1);
                        if (r_acc_cnt == c_LAST) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Wait for the final bundle to leave stage 1 so the
                    // verdict sees the fully updated error count.
                    if (!r_s1_valid) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign vec_count    = r_vec_count;
    assign err_count    = r_err_count;
    assign fail_valid   = r_fail_valid;
    assign fail_idx     = r_fail_idx;
    assign fail_obs     = r_fail_obs;

endmodule : cla_response_checker
`default_nettype wire
